// File: rtl/vga_pkg.sv
// Shared timing defaults, polarity constants, width helper and RGB packing
// order for the VGA scan controller.
package vga_pkg;

  // 640x480@60 timing, 25.175 MHz pixel rate
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP   = 48;
  localparam int DEF_H_ACT  = 640;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP   = 33;
  localparam int DEF_V_ACT  = 480;
  localparam int DEF_V_FP   = 10;

  localparam int POL_LOW  = 0;
  localparam int POL_HIGH = 1;

  // Channel slots inside a packed {r,g,b} word, counted from the LSB.
  localparam int RGB_R_SLOT = 2;
  localparam int RGB_G_SLOT = 1;
  localparam int RGB_B_SLOT = 0;

  function automatic int width_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Enable-qualified shift register of configurable depth; re-aligns the raw
// sync/active bits with video-memory read data.
module vga_sync_delay #(
  parameter int             DEPTH   = 1,
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  if (DEPTH == 0) begin : g_pass
    logic unused_ctrl;
    assign unused_ctrl = ^{clock, resetn, en};
    assign q = d;
  end else begin : g_pipe
    logic [W-1:0] pipe [DEPTH];

    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        for (int i = 0; i < DEPTH; i++) pipe[i] <= RST_VAL;
      end else if (en) begin
        pipe[0] <= d;
        for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
      end
    end

    assign q = pipe[DEPTH-1];
  end

endmodule

// File: rtl/vga_scan_ctrl.sv
// Parametrised VGA timing generator: scan counters, pixel address stage,
// latency-matched sync/blank pipeline and registered pin outputs.
module vga_scan_ctrl
  import vga_pkg::*;
#(
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP   = DEF_H_BP,
  parameter int H_ACT  = DEF_H_ACT,
  parameter int H_FP   = DEF_H_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP   = DEF_V_BP,
  parameter int V_ACT  = DEF_V_ACT,
  parameter int V_FP   = DEF_V_FP,
  parameter int HS_POL = POL_LOW,
  parameter int VS_POL = POL_LOW,
  parameter int CW     = 8,
  parameter int RD_LAT = 1,
  parameter int FC_W   = 16,
  parameter logic [3*CW-1:0] BLANK_RGB = '0
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         pix_en,
  input  logic [3*CW-1:0]              vga_data,
  output logic [width_of(H_ACT)-1:0]   h_addr,
  output logic [width_of(V_ACT)-1:0]   v_addr,
  output logic                         addr_req,
  output logic                         hsync,
  output logic                         vsync,
  output logic                         valid,
  output logic [CW-1:0]                vga_r,
  output logic [CW-1:0]                vga_g,
  output logic [CW-1:0]                vga_b,
  output logic                         line_start,
  output logic                         frame_start,
  output logic [FC_W-1:0]              frame_cnt
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;
  localparam int HCW = width_of(H_TOTAL);
  localparam int VCW = width_of(V_TOTAL);
  localparam int HAW = width_of(H_ACT);
  localparam int VAW = width_of(V_ACT);
  localparam int H_ACT_START = H_SYNC + H_BP;
  localparam int V_ACT_START = V_SYNC + V_BP;
  localparam logic HS_ON = (HS_POL != 0);
  localparam logic VS_ON = (VS_POL != 0);

  if (RD_LAT < 0 || RD_LAT > 4 || H_SYNC < 1 || H_BP < 1 || H_ACT < 1 || H_FP < 1 ||
      V_SYNC < 1 || V_BP < 1 || V_ACT < 1 || V_FP < 1 || CW < 1 || FC_W < 1) begin : g_bad_cfg
    $error("vga_scan_ctrl: RD_LAT outside 0..4 or a zero-width timing region");
  end

  logic [HCW-1:0] h_cnt;
  logic [VCW-1:0] v_cnt;
  logic           h_last, v_last;
  logic           h_act, v_act;
  logic           hs_raw, vs_raw;
  logic [2:0]     raw_bits, dly_bits;
  logic [3*CW-1:0] rgb_q;

  assign h_last = (h_cnt == HCW'(H_TOTAL - 1));
  assign v_last = (v_cnt == VCW'(V_TOTAL - 1));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      frame_cnt <= '0;
    end else if (pix_en) begin
      if (h_last) begin
        h_cnt <= '0;
        if (v_last) begin
          v_cnt     <= '0;
          frame_cnt <= frame_cnt + FC_W'(1);
        end else begin
          v_cnt <= v_cnt + VCW'(1);
        end
      end else begin
        h_cnt <= h_cnt + HCW'(1);
      end
    end
  end

  // Address stage reads the counter registers directly: no extra latency.
  always_comb begin
    h_act    = (h_cnt >= HCW'(H_ACT_START)) && (h_cnt < HCW'(H_ACT_START + H_ACT));
    v_act    = (v_cnt >= VCW'(V_ACT_START)) && (v_cnt < VCW'(V_ACT_START + V_ACT));
    hs_raw   = (h_cnt < HCW'(H_SYNC));
    vs_raw   = (v_cnt < VCW'(V_SYNC));
    addr_req = h_act && v_act;
    h_addr   = h_act ? HAW'(h_cnt - HCW'(H_ACT_START)) : '0;
    v_addr   = v_act ? VAW'(v_cnt - VCW'(V_ACT_START)) : '0;
  end

  assign line_start  = pix_en && (h_cnt == '0);
  assign frame_start = line_start && (v_cnt == '0);

  assign raw_bits = {hs_raw, vs_raw, addr_req};

  vga_sync_delay #(
    .DEPTH  (RD_LAT),
    .W      (3),
    .RST_VAL(3'b000)
  ) u_sync_delay (
    .clock (clock),
    .resetn(resetn),
    .en    (pix_en),
    .d     (raw_bits),
    .q     (dly_bits)
  );

  // Final register adds the one pix_en cycle that pairs with the memory read.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      hsync <= ~HS_ON;
      vsync <= ~VS_ON;
      valid <= 1'b0;
      rgb_q <= BLANK_RGB;
    end else if (pix_en) begin
      hsync <= dly_bits[2] ? HS_ON : ~HS_ON;
      vsync <= dly_bits[1] ? VS_ON : ~VS_ON;
      valid <= dly_bits[0];
      rgb_q <= dly_bits[0] ? vga_data : BLANK_RGB;
    end
  end

  assign vga_r = rgb_q[RGB_R_SLOT*CW +: CW];
  assign vga_g = rgb_q[RGB_G_SLOT*CW +: CW];
  assign vga_b = rgb_q[RGB_B_SLOT*CW +: CW];

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Bench for vga_scan_ctrl: three shrunken-timing instances (RD_LAT 2/1/0)
// compared each clock against an arithmetic scan-position reference.
module tb_vga_scan_ctrl;

  typedef struct {
    int hs, hbp, hact, hfp, vs, vbp, vact, vfp, hpol, vpol, rdl, fcw;
    logic [23:0] blank;
  } geo_t;

  logic clock = 1'b0;
  logic resetn;
  logic pix_en;
  int   n;
  int   total;
  int   bad;
  geo_t ga, gb, gc;

  always #5 clock = ~clock;

  // instance a: RD_LAT=2, active-low syncs
  logic [23:0] a_data;
  logic [4:0]  a_haddr;
  logic [2:0]  a_vaddr;
  logic        a_req, a_hs, a_vs, a_val, a_ls, a_fs;
  logic [7:0]  a_r, a_g, a_b;
  logic [15:0] a_fc;
  // instance b: RD_LAT=1, nonzero blank colour
  logic [23:0] b_data;
  logic [3:0]  b_haddr;
  logic [2:0]  b_vaddr;
  logic        b_req, b_hs, b_vs, b_val, b_ls, b_fs;
  logic [7:0]  b_r, b_g, b_b;
  logic [15:0] b_fc;
  // instance c: tiny timing, RD_LAT=0, active-high syncs, 2-bit frame count
  logic [23:0] c_data;
  logic [1:0]  c_haddr;
  logic [0:0]  c_vaddr;
  logic        c_req, c_hs, c_vs, c_val, c_ls, c_fs;
  logic [7:0]  c_r, c_g, c_b;
  logic [1:0]  c_fc;

  vga_scan_ctrl #(.H_SYNC(8), .H_BP(6), .H_ACT(20), .H_FP(4), .V_SYNC(2), .V_BP(3), .V_ACT(6),
    .V_FP(2), .HS_POL(0), .VS_POL(0), .CW(8), .RD_LAT(2), .FC_W(16), .BLANK_RGB(24'h000000)) dut_a (
    .clock(clock), .resetn(resetn), .pix_en(pix_en), .vga_data(a_data), .h_addr(a_haddr),
    .v_addr(a_vaddr), .addr_req(a_req), .hsync(a_hs), .vsync(a_vs), .valid(a_val), .vga_r(a_r),
    .vga_g(a_g), .vga_b(a_b), .line_start(a_ls), .frame_start(a_fs), .frame_cnt(a_fc));

  vga_scan_ctrl #(.H_SYNC(10), .H_BP(5), .H_ACT(16), .H_FP(3), .V_SYNC(2), .V_BP(2), .V_ACT(5),
    .V_FP(1), .HS_POL(0), .VS_POL(0), .CW(8), .RD_LAT(1), .FC_W(16), .BLANK_RGB(24'h123456)) dut_b (
    .clock(clock), .resetn(resetn), .pix_en(pix_en), .vga_data(b_data), .h_addr(b_haddr),
    .v_addr(b_vaddr), .addr_req(b_req), .hsync(b_hs), .vsync(b_vs), .valid(b_val), .vga_r(b_r),
    .vga_g(b_g), .vga_b(b_b), .line_start(b_ls), .frame_start(b_fs), .frame_cnt(b_fc));

  vga_scan_ctrl #(.H_SYNC(2), .H_BP(2), .H_ACT(4), .H_FP(2), .V_SYNC(1), .V_BP(1), .V_ACT(2),
    .V_FP(1), .HS_POL(1), .VS_POL(1), .CW(8), .RD_LAT(0), .FC_W(2), .BLANK_RGB(24'hABCDEF)) dut_c (
    .clock(clock), .resetn(resetn), .pix_en(pix_en), .vga_data(c_data), .h_addr(c_haddr),
    .v_addr(c_vaddr), .addr_req(c_req), .hsync(c_hs), .vsync(c_vs), .valid(c_val), .vga_r(c_r),
    .vga_g(c_g), .vga_b(c_b), .line_start(c_ls), .frame_start(c_fs), .frame_cnt(c_fc));

  function automatic logic [23:0] mem_word(input int h, input int v);
    logic [7:0] hb, vb;
    hb = h[7:0];
    vb = v[7:0];
    return {hb, vb, 8'h5A};
  endfunction

  // Video memories: pipelines that advance on pix_en, depth = RD_LAT.
  logic [23:0] mem_a1, mem_a2, mem_b1;
  always @(posedge clock) begin
    if (pix_en) begin
      mem_a1 <= mem_word(int'(a_haddr), int'(a_vaddr));
      mem_a2 <= mem_a1;
      mem_b1 <= mem_word(int'(b_haddr), int'(b_vaddr));
    end
  end
  assign a_data = mem_a2;
  assign b_data = mem_b1;
  assign c_data = mem_word(int'(c_haddr), int'(c_vaddr));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (n=%0d)", tag, obs, exp, n);
    end
  endtask

  // Expected pin state after n enabled edges: pins show scan position n-1-RD_LAT.
  task automatic check_regs(input string tag, input geo_t g, input logic hs_o, input logic vs_o,
                            input logic val_o, input logic [23:0] rgb_o, input logic [31:0] fc_o);
    int ht, vt, p, h, v;
    logic act, hs_e, vs_e;
    logic [23:0] rgb_e;
    ht = g.hs + g.hbp + g.hact + g.hfp;
    vt = g.vs + g.vbp + g.vact + g.vfp;
    p  = n - 1 - g.rdl;
    if (p < 0) begin
      hs_e  = (g.hpol == 0);
      vs_e  = (g.vpol == 0);
      act   = 1'b0;
      rgb_e = g.blank;
    end else begin
      h     = p % ht;
      v     = (p / ht) % vt;
      act   = (h >= g.hs + g.hbp) && (h < g.hs + g.hbp + g.hact) &&
              (v >= g.vs + g.vbp) && (v < g.vs + g.vbp + g.vact);
      hs_e  = (h < g.hs) ? (g.hpol != 0) : (g.hpol == 0);
      vs_e  = (v < g.vs) ? (g.vpol != 0) : (g.vpol == 0);
      rgb_e = act ? mem_word(h - g.hs - g.hbp, v - g.vs - g.vbp) : g.blank;
    end
    chk({tag, ".hsync"}, 32'(hs_o), 32'(hs_e));
    chk({tag, ".vsync"}, 32'(vs_o), 32'(vs_e));
    chk({tag, ".valid"}, 32'(val_o), 32'(act));
    chk({tag, ".rgb"}, 32'(rgb_o), 32'(rgb_e));
    chk({tag, ".frame_cnt"}, fc_o, 32'((n / (ht * vt)) % (1 << g.fcw)));
  endtask

  // Address and strobe outputs reflect the current scan position n.
  task automatic check_comb(input string tag, input geo_t g, input logic pe, input logic [31:0] ha_o,
                            input logic [31:0] va_o, input logic req_o, input logic ls_o,
                            input logic fs_o);
    int ht, vt, h, v;
    logic hin, vin;
    ht  = g.hs + g.hbp + g.hact + g.hfp;
    vt  = g.vs + g.vbp + g.vact + g.vfp;
    h   = n % ht;
    v   = (n / ht) % vt;
    hin = (h >= g.hs + g.hbp) && (h < g.hs + g.hbp + g.hact);
    vin = (v >= g.vs + g.vbp) && (v < g.vs + g.vbp + g.vact);
    chk({tag, ".h_addr"}, ha_o, hin ? 32'(h - g.hs - g.hbp) : 32'd0);
    chk({tag, ".v_addr"}, va_o, vin ? 32'(v - g.vs - g.vbp) : 32'd0);
    chk({tag, ".addr_req"}, 32'(req_o), 32'(hin && vin));
    chk({tag, ".line_start"}, 32'(ls_o), 32'(pe && h == 0));
    chk({tag, ".frame_start"}, 32'(fs_o), 32'(pe && h == 0 && v == 0));
  endtask

  task automatic check_all_regs();
    check_regs("a", ga, a_hs, a_vs, a_val, {a_r, a_g, a_b}, 32'(a_fc));
    check_regs("b", gb, b_hs, b_vs, b_val, {b_r, b_g, b_b}, 32'(b_fc));
    check_regs("c", gc, c_hs, c_vs, c_val, {c_r, c_g, c_b}, 32'(c_fc));
  endtask

  task automatic check_reset_state(input string tag);
    n = 0;
    check_all_regs();
    chk({tag, ".a_addr_req"}, 32'(a_req), 32'd0);
    chk({tag, ".b_h_addr"}, 32'(b_haddr), 32'd0);
    chk({tag, ".c_v_addr"}, 32'(c_vaddr), 32'd0);
  endtask

  task automatic step(input logic pe);
    @(negedge clock);
    pix_en = pe;
    #1;
    check_comb("a", ga, pe, 32'(a_haddr), 32'(a_vaddr), a_req, a_ls, a_fs);
    check_comb("b", gb, pe, 32'(b_haddr), 32'(b_vaddr), b_req, b_ls, b_fs);
    check_comb("c", gc, pe, 32'(c_haddr), 32'(c_vaddr), c_req, c_ls, c_fs);
    @(posedge clock);
    if (pe) n++;
    #1;
    check_all_regs();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    n     = 0;
    ga = '{hs: 8, hbp: 6, hact: 20, hfp: 4, vs: 2, vbp: 3, vact: 6, vfp: 2,
           hpol: 0, vpol: 0, rdl: 2, fcw: 16, blank: 24'h000000};
    gb = '{hs: 10, hbp: 5, hact: 16, hfp: 3, vs: 2, vbp: 2, vact: 5, vfp: 1,
           hpol: 0, vpol: 0, rdl: 1, fcw: 16, blank: 24'h123456};
    gc = '{hs: 2, hbp: 2, hact: 4, hfp: 2, vs: 1, vbp: 1, vact: 2, vfp: 1,
           hpol: 1, vpol: 1, rdl: 0, fcw: 2, blank: 24'hABCDEF};

    resetn = 1'b0;
    pix_en = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check_reset_state("rst");
    @(posedge clock);
    #1 resetn = 1'b1;

    // continuous enable: several frames on every instance, c wraps frame_cnt
    for (int i = 0; i < 1200; i++) step(1'b1);
    // enable held low: everything frozen, strobes silent
    for (int i = 0; i < 60; i++) step(1'b0);
    // half-rate enable
    for (int i = 0; i < 400; i++) step(i % 2 == 0);
    // random enable
    for (int i = 0; i < 1500; i++) step($urandom_range(0, 3) != 0);

    // asynchronous reset mid-frame, observed before the next clock edge
    #2 resetn = 1'b0;
    #1;
    check_reset_state("mid_rst");
    @(posedge clock);
    #1 resetn = 1'b1;
    for (int i = 0; i < 800; i++) step($urandom_range(0, 4) != 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
